// File: rtl/inventory_slot_ctrl_pkg.sv
// Shared encodings for the tag inventory path (slot controller and RNG):
// tag states, reader command codes, QueryAdjust codes and the Q adjust helper.
package inventory_slot_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_READY     = 2'd0,
    ST_ARBITRATE = 2'd1,
    ST_REPLY     = 2'd2,
    ST_ACKED     = 2'd3
  } tag_state_e;

  typedef enum logic [2:0] {
    CMD_OTHER    = 3'd0,
    CMD_QUERY    = 3'd1,
    CMD_QUERYREP = 3'd2,
    CMD_QUERYADJ = 3'd3,
    CMD_ACK      = 3'd4,
    CMD_NAK      = 3'd5
  } cmd_type_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_STROBE = 2'd1,
    PH_WAIT   = 2'd2,
    PH_EVAL   = 2'd3
  } eval_phase_e;

  typedef enum logic {
    SLOT_NEW = 1'b0,
    SLOT_DEC = 1'b1
  } slot_op_e;

  localparam logic [2:0] UPDN_UP   = 3'b110;
  localparam logic [2:0] UPDN_DOWN = 3'b011;
  localparam logic [2:0] UPDN_HOLD = 3'b000;

  function automatic logic updn_valid(input logic [2:0] updn);
    return (updn == UPDN_UP) || (updn == UPDN_DOWN) || (updn == UPDN_HOLD);
  endfunction

  // Saturating Q step; codes outside the three legal ones leave Q alone.
  function automatic logic [3:0] q_adjust(input logic [3:0] q, input logic [2:0] updn);
    logic [3:0] q_next;
    q_next = q;
    if (updn == UPDN_UP && q != 4'd15)
      q_next = q + 4'd1;
    else if (updn == UPDN_DOWN && q != 4'd0)
      q_next = q - 4'd1;
    return q_next;
  endfunction

endpackage

// File: rtl/inventory_slot_ctrl.sv
// Tag inventory controller: turns reader commands into Q updates and slot
// strobes for the RNG, then evaluates slot-zero to decide on an RN16 reply.
module inventory_slot_ctrl
  import inventory_slot_ctrl_pkg::*;
#(
  parameter logic [3:0] Q_INIT = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  input  logic [2:0]  i_cmd_type,
  input  logic [3:0]  i_cmd_q,
  input  logic [2:0]  i_cmd_updn,
  input  logic [15:0] i_cmd_rn16,
  input  logic [15:0] i_random_rng,
  input  logic        i_slotz_rng,
  output logic [3:0]  o_q_dec,
  output logic        o_newSlot_cu,
  output logic        o_decSlot_cu,
  output logic [15:0] o_rn16,
  output logic        o_reply_rn16,
  output logic        o_reply_epc,
  output logic [1:0]  o_state,
  output logic        o_busy
);

  tag_state_e  state_q, state_d;
  eval_phase_e phase_q, phase_d;
  slot_op_e    op_q, op_d;
  logic [3:0]  q_q, q_d;
  logic [15:0] rn16_q, rn16_d;
  logic        reply_rn16_q, reply_rn16_d;
  logic        reply_epc_q, reply_epc_d;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_READY;
      phase_q      <= PH_IDLE;
      op_q         <= SLOT_NEW;
      q_q          <= Q_INIT;
      rn16_q       <= 16'd0;
      reply_rn16_q <= 1'b0;
      reply_epc_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      op_q         <= op_d;
      q_q          <= q_d;
      rn16_q       <= rn16_d;
      reply_rn16_q <= reply_rn16_d;
      reply_epc_q  <= reply_epc_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    state_d      = state_q;
    phase_d      = phase_q;
    op_d         = op_q;
    q_d          = q_q;
    rn16_d       = rn16_q;
    reply_rn16_d = 1'b0;
    reply_epc_d  = 1'b0;

    unique case (phase_q)
      PH_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd_type)
            CMD_QUERY: begin
              q_d     = i_cmd_q;
              op_d    = SLOT_NEW;
              phase_d = PH_STROBE;
            end
            CMD_QUERYADJ: begin
              if (state_q != ST_READY && updn_valid(i_cmd_updn)) begin
                q_d     = q_adjust(q_q, i_cmd_updn);
                op_d    = SLOT_NEW;
                phase_d = PH_STROBE;
              end
            end
            CMD_QUERYREP: begin
              case (state_q)
                ST_ARBITRATE: begin
                  op_d    = SLOT_DEC;
                  phase_d = PH_STROBE;
                end
                ST_REPLY: state_d = ST_ARBITRATE;
                ST_ACKED: state_d = ST_READY;
                default:  state_d = state_q;
              endcase
            end
            CMD_ACK: begin
              if (state_q == ST_REPLY || state_q == ST_ACKED) begin
                if (i_cmd_rn16 == rn16_q) begin
                  state_d     = ST_ACKED;
                  reply_epc_d = 1'b1;
                end else begin
                  state_d = ST_ARBITRATE;
                end
              end
            end
            CMD_NAK: begin
              if (state_q != ST_READY) state_d = ST_ARBITRATE;
            end
            default: state_d = state_q;
          endcase
        end
      end
      PH_STROBE: begin
        // The RNG loads its slot counter on this same edge from i_random_rng.
        if (op_q == SLOT_NEW) rn16_d = i_random_rng;
        phase_d = PH_WAIT;
      end
      PH_WAIT: phase_d = PH_EVAL;
      PH_EVAL: begin
        phase_d = PH_IDLE;
        if (i_slotz_rng) begin
          state_d      = ST_REPLY;
          reply_rn16_d = 1'b1;
        end else begin
          state_d = ST_ARBITRATE;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  assign o_q_dec      = q_q;
  assign o_newSlot_cu = (phase_q == PH_STROBE) && (op_q == SLOT_NEW);
  assign o_decSlot_cu = (phase_q == PH_STROBE) && (op_q == SLOT_DEC);
  assign o_rn16       = rn16_q;
  assign o_reply_rn16 = reply_rn16_q;
  assign o_reply_epc  = reply_epc_q;
  assign o_state      = state_q;
  assign o_busy       = (phase_q != PH_IDLE);

endmodule

// File: tb/tb_inventory_slot_ctrl.sv
// Directed bench for inventory_slot_ctrl: the RNG is played by hand-set
// i_random_rng / i_slotz_rng values; strobes are counted by a monitor.
module tb_inventory_slot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cmd_valid;
  logic [2:0]  i_cmd_type;
  logic [3:0]  i_cmd_q;
  logic [2:0]  i_cmd_updn;
  logic [15:0] i_cmd_rn16;
  logic [15:0] i_random_rng;
  logic        i_slotz_rng;
  logic [3:0]  o_q_dec;
  logic        o_newSlot_cu;
  logic        o_decSlot_cu;
  logic [15:0] o_rn16;
  logic        o_reply_rn16;
  logic        o_reply_epc;
  logic [1:0]  o_state;
  logic        o_busy;

  int tests = 0;
  int fails = 0;
  int n_new = 0;
  int n_dec = 0;
  int n_rrn = 0;
  int n_epc = 0;
  int excl_viol = 0;

  localparam logic [2:0] T_QUERY = 3'd1, T_REP = 3'd2, T_ADJ = 3'd3, T_ACK = 3'd4;
  localparam logic [1:0] S_READY = 2'd0, S_ARB = 2'd1, S_REPLY = 2'd2, S_ACKED = 2'd3;

  inventory_slot_ctrl #(.Q_INIT(4'd4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (i_cmd_valid),
    .i_cmd_type   (i_cmd_type),
    .i_cmd_q      (i_cmd_q),
    .i_cmd_updn   (i_cmd_updn),
    .i_cmd_rn16   (i_cmd_rn16),
    .i_random_rng (i_random_rng),
    .i_slotz_rng  (i_slotz_rng),
    .o_q_dec      (o_q_dec),
    .o_newSlot_cu (o_newSlot_cu),
    .o_decSlot_cu (o_decSlot_cu),
    .o_rn16       (o_rn16),
    .o_reply_rn16 (o_reply_rn16),
    .o_reply_epc  (o_reply_epc),
    .o_state      (o_state),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  // Counts each strobe over the cycle that ends at this edge.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_newSlot_cu) n_new++;
      if (o_decSlot_cu) n_dec++;
      if (o_reply_rn16) n_rrn++;
      if (o_reply_epc)  n_epc++;
      if ($countones({o_newSlot_cu, o_decSlot_cu, o_reply_rn16, o_reply_epc}) > 1) excl_viol++;
    end
  end

  // Presents one command for one cycle, starting and ending on a falling edge.
  task automatic issue(input logic [2:0] t, input logic [3:0] q, input logic [2:0] ud,
                       input logic [15:0] rn);
    i_cmd_valid = 1'b1; i_cmd_type = t; i_cmd_q = q; i_cmd_updn = ud; i_cmd_rn16 = rn;
    @(negedge clk);
    i_cmd_valid = 1'b0; i_cmd_type = 3'd0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_type = 3'd0; i_cmd_q = 4'd0; i_cmd_updn = 3'd0;
    i_cmd_rn16 = 16'd0; i_random_rng = 16'd0; i_slotz_rng = 1'b0;
    wait_cycles(2);
    tests++; if (o_state !== S_READY) begin fails++; $display("FAIL reset_state: got %0d want %0d", o_state, S_READY); end
    tests++; if (o_q_dec !== 4'd4) begin fails++; $display("FAIL reset_q: got %0d want 4", o_q_dec); end
    tests++; if (o_rn16 !== 16'd0) begin fails++; $display("FAIL reset_rn16: got %h want 0000", o_rn16); end
    tests++; if ({o_newSlot_cu, o_decSlot_cu, o_reply_rn16, o_reply_epc, o_busy} !== 5'b0) begin
      fails++; $display("FAIL reset_strobes: got %b want 00000", {o_newSlot_cu, o_decSlot_cu, o_reply_rn16, o_reply_epc, o_busy}); end
    rst_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_query_q0;
    int new0;
    new0 = n_new;
    i_random_rng = 16'hA5C3; i_slotz_rng = 1'b1;
    issue(T_QUERY, 4'd0, 3'd0, 16'd0);
    tests++; if (o_newSlot_cu !== 1'b1) begin fails++; $display("FAIL q0_newslot: got %b want 1", o_newSlot_cu); end
    tests++; if (o_q_dec !== 4'd0) begin fails++; $display("FAIL q0_q: got %0d want 0", o_q_dec); end
    tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL q0_busy: got %b want 1", o_busy); end
    wait_cycles(1);
    tests++; if (o_rn16 !== 16'hA5C3) begin fails++; $display("FAIL q0_rn16: got %h want a5c3", o_rn16); end
    tests++; if (o_newSlot_cu !== 1'b0) begin fails++; $display("FAIL q0_newslot_off: got %b want 0", o_newSlot_cu); end
    wait_cycles(2);
    tests++; if (o_state !== S_REPLY) begin fails++; $display("FAIL q0_state: got %0d want %0d", o_state, S_REPLY); end
    tests++; if (o_reply_rn16 !== 1'b1) begin fails++; $display("FAIL q0_reply: got %b want 1", o_reply_rn16); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL q0_busy_off: got %b want 0", o_busy); end
    wait_cycles(1);
    tests++; if (o_reply_rn16 !== 1'b0) begin fails++; $display("FAIL q0_reply_off: got %b want 0", o_reply_rn16); end
    tests++; if (n_new - new0 !== 1) begin fails++; $display("FAIL q0_newslot_count: got %0d want 1", n_new - new0); end
  endtask

  task automatic test_queryrep;
    int rrn0;
    i_random_rng = 16'h1233; i_slotz_rng = 1'b0;
    issue(T_QUERY, 4'd4, 3'd0, 16'd0);
    wait_cycles(3);
    tests++; if (o_state !== S_ARB) begin fails++; $display("FAIL rep_arb: got %0d want %0d", o_state, S_ARB); end
    tests++; if (o_rn16 !== 16'h1233) begin fails++; $display("FAIL rep_rn16: got %h want 1233", o_rn16); end
    rrn0 = n_rrn;
    for (int i = 0; i < 3; i++) begin
      i_slotz_rng = (i == 2);
      issue(T_REP, 4'd0, 3'd0, 16'd0);
      tests++; if (o_decSlot_cu !== 1'b1) begin fails++; $display("FAIL rep_dec%0d: got %b want 1", i, o_decSlot_cu); end
      tests++; if (o_q_dec !== 4'd4) begin fails++; $display("FAIL rep_q%0d: got %0d want 4", i, o_q_dec); end
      wait_cycles(3);
      tests++; if (o_state !== ((i == 2) ? S_REPLY : S_ARB)) begin
        fails++; $display("FAIL rep_state%0d: got %0d want %0d", i, o_state, (i == 2) ? S_REPLY : S_ARB); end
      tests++; if (o_reply_rn16 !== (i == 2)) begin fails++; $display("FAIL rep_reply%0d: got %b want %b", i, o_reply_rn16, i == 2); end
    end
    wait_cycles(1);
    tests++; if (n_rrn - rrn0 !== 1) begin fails++; $display("FAIL rep_reply_count: got %0d want 1", n_rrn - rrn0); end
    tests++; if (o_rn16 !== 16'h1233) begin fails++; $display("FAIL rep_rn16_kept: got %h want 1233", o_rn16); end
  endtask

  task automatic test_ack;
    int epc0;
    issue(T_ACK, 4'd0, 3'd0, 16'h1233);
    tests++; if (o_reply_epc !== 1'b1) begin fails++; $display("FAIL ack_epc: got %b want 1", o_reply_epc); end
    tests++; if (o_state !== S_ACKED) begin fails++; $display("FAIL ack_state: got %0d want %0d", o_state, S_ACKED); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL ack_busy: got %b want 0", o_busy); end
    wait_cycles(1);
    tests++; if (o_reply_epc !== 1'b0) begin fails++; $display("FAIL ack_epc_off: got %b want 0", o_reply_epc); end
    i_random_rng = 16'hBEEF; i_slotz_rng = 1'b1;
    issue(T_QUERY, 4'd0, 3'd0, 16'd0);
    wait_cycles(3);
    tests++; if (o_state !== S_REPLY) begin fails++; $display("FAIL nack_pre_state: got %0d want %0d", o_state, S_REPLY); end
    epc0 = n_epc;
    i_slotz_rng = 1'b0;
    issue(T_ACK, 4'd0, 3'd0, 16'hBEEF ^ 16'h0001);
    tests++; if (o_state !== S_ARB) begin fails++; $display("FAIL nack_state: got %0d want %0d", o_state, S_ARB); end
    tests++; if (o_reply_epc !== 1'b0) begin fails++; $display("FAIL nack_epc: got %b want 0", o_reply_epc); end
    wait_cycles(1);
    tests++; if (n_epc !== epc0) begin fails++; $display("FAIL nack_epc_count: got %0d want %0d", n_epc, epc0); end
  endtask

  task automatic test_queryadj;
    i_slotz_rng = 1'b0;
    issue(T_QUERY, 4'd15, 3'd0, 16'd0); wait_cycles(3);
    issue(T_ADJ, 4'd0, 3'b110, 16'd0);
    tests++; if (o_q_dec !== 4'd15) begin fails++; $display("FAIL adj_up_sat: got %0d want 15", o_q_dec); end
    tests++; if (o_newSlot_cu !== 1'b1) begin fails++; $display("FAIL adj_up_newslot: got %b want 1", o_newSlot_cu); end
    wait_cycles(3);
    issue(T_QUERY, 4'd0, 3'd0, 16'd0); wait_cycles(3);
    issue(T_ADJ, 4'd0, 3'b011, 16'd0);
    tests++; if (o_q_dec !== 4'd0) begin fails++; $display("FAIL adj_down_sat: got %0d want 0", o_q_dec); end
    tests++; if (o_newSlot_cu !== 1'b1) begin fails++; $display("FAIL adj_down_newslot: got %b want 1", o_newSlot_cu); end
    wait_cycles(3);
    issue(T_ADJ, 4'd0, 3'b110, 16'd0);
    tests++; if (o_q_dec !== 4'd1) begin fails++; $display("FAIL adj_up: got %0d want 1", o_q_dec); end
    wait_cycles(3);
    issue(T_ADJ, 4'd0, 3'b101, 16'd0);
    tests++; if ({o_newSlot_cu, o_busy} !== 2'b00) begin fails++; $display("FAIL adj_bad_strobe: got %b want 00", {o_newSlot_cu, o_busy}); end
    tests++; if (o_q_dec !== 4'd1) begin fails++; $display("FAIL adj_bad_q: got %0d want 1", o_q_dec); end
    tests++; if (o_state !== S_ARB) begin fails++; $display("FAIL adj_bad_state: got %0d want %0d", o_state, S_ARB); end
  endtask

  task automatic test_back_to_back;
    int new0;
    new0 = n_new;
    i_slotz_rng = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_type = T_QUERY; i_cmd_q = 4'd2;
    @(negedge clk);
    tests++; if ({o_newSlot_cu, o_busy} !== 2'b11) begin fails++; $display("FAIL b2b_first: got %b want 11", {o_newSlot_cu, o_busy}); end
    i_cmd_q = 4'd7;
    @(negedge clk);
    tests++; if (o_q_dec !== 4'd2) begin fails++; $display("FAIL b2b_q_n2: got %0d want 2", o_q_dec); end
    @(negedge clk);
    i_cmd_valid = 1'b0; i_cmd_type = 3'd0;
    wait_cycles(3);
    tests++; if (o_q_dec !== 4'd2) begin fails++; $display("FAIL b2b_q: got %0d want 2", o_q_dec); end
    tests++; if (n_new - new0 !== 1) begin fails++; $display("FAIL b2b_newslot_count: got %0d want 1", n_new - new0); end
  endtask

  task automatic test_reset_mid;
    int new0, rrn0;
    i_random_rng = 16'h5A5A; i_slotz_rng = 1'b1;
    issue(T_QUERY, 4'd9, 3'd0, 16'd0);
    wait_cycles(1);
    rst_n = 1'b0;
    #1;
    tests++; if (o_state !== S_READY) begin fails++; $display("FAIL rstmid_state: got %0d want %0d", o_state, S_READY); end
    tests++; if (o_q_dec !== 4'd4) begin fails++; $display("FAIL rstmid_q: got %0d want 4", o_q_dec); end
    tests++; if (o_rn16 !== 16'd0) begin fails++; $display("FAIL rstmid_rn16: got %h want 0000", o_rn16); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    new0 = n_new; rrn0 = n_rrn;
    wait_cycles(5);
    tests++; if ((n_new - new0) + (n_rrn - rrn0) !== 0) begin
      fails++; $display("FAIL rstmid_no_strobe: got %0d want 0", (n_new - new0) + (n_rrn - rrn0)); end
    tests++; if (o_state !== S_READY) begin fails++; $display("FAIL rstmid_state_after: got %0d want %0d", o_state, S_READY); end
    issue(T_ADJ, 4'd0, 3'b110, 16'd0);
    tests++; if ({o_newSlot_cu, o_busy} !== 2'b00 || o_q_dec !== 4'd4) begin
      fails++; $display("FAIL ready_adj_ignored: got strobe/busy %b q %0d want 00 q 4", {o_newSlot_cu, o_busy}, o_q_dec); end
  endtask

  initial begin
    test_reset();
    test_query_q0();
    test_queryrep();
    test_ack();
    test_queryadj();
    test_back_to_back();
    test_reset_mid();
    tests++; if (excl_viol !== 0) begin fails++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", excl_viol); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inventory_slot_ctrl.md
Name: inventory_slot_ctrl

Overview:
- Tag-side inventory controller directly upstream of random_generator.
- Consumes decoded reader commands (Query, QueryRep, QueryAdjust, ACK, NAK). Drives the RNG's Q value and its new-slot/dec-slot strobes, then samples the RNG's slot-zero flag to decide whether to backscatter.
- Latches the RN16 that was loaded into the slot counter, and compares it against the ACK payload.
- Output strobes go to the reply/encoder stage.

Parameters:
- Q_INIT, 4'd4, Q value after reset.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- i_cmd_valid  input  1  one-cycle strobe; command fields valid
- i_cmd_type  input  3  0 other/ignore, 1 QUERY, 2 QUERYREP, 3 QUERYADJ, 4 ACK, 5 NAK
- i_cmd_q  input  4  Q field of QUERY
- i_cmd_updn  input  3  QUERYADJ field: 3'b110 up, 3'b011 down, 3'b000 hold
- i_cmd_rn16  input  16  RN16 field of ACK
- i_random_rng  input  16  current RNG output
- i_slotz_rng  input  1  slot counter masked to Q bits equals zero
- o_q_dec  output  4  current Q, to RNG
- o_newSlot_cu  output  1  one-cycle strobe: load slot counter from RNG
- o_decSlot_cu  output  1  one-cycle strobe: decrement slot counter
- o_rn16  output  16  RN16 latched at last new-slot
- o_reply_rn16  output  1  one-cycle strobe: backscatter o_rn16
- o_reply_epc  output  1  one-cycle strobe: backscatter PC/EPC
- o_state  output  2  0 READY, 1 ARBITRATE, 2 REPLY, 3 ACKNOWLEDGED
- o_busy  output  1  slot evaluation in progress; commands dropped

Behaviour:
- Reset values: o_state=READY, o_q_dec=Q_INIT, o_rn16=0. All strobes and o_busy are 0.
- Commands are accepted only when i_cmd_valid=1 and o_busy=0. Commands arriving while busy are silently dropped.
- Internal evaluation phases: IDLE, then STROBE (1 cycle), then WAIT (1 cycle), then EVAL (1 cycle), then IDLE.
  - o_busy is high in STROBE, WAIT and EVAL.
  - The command is accepted in cycle N; the strobe is asserted in cycle N+1.
  - The RNG slot register updates at the end of N+1, so slotz is stable in N+2.
  - i_slotz_rng is sampled at the end of N+3 (EVAL). The state update and any o_reply_rn16 strobe occur in cycle N+4.
- New-slot sequence: o_newSlot_cu=1 for one cycle. In that same cycle o_rn16 <= i_random_rng, which is the value the RNG loads into the slot counter.
- Dec-slot sequence: o_decSlot_cu=1 for one cycle. o_rn16 is unchanged.
- EVAL outcome:
  - slotz=1: state becomes REPLY and o_reply_rn16 pulses for 1 cycle.
  - slotz=0: state becomes ARBITRATE.
- QUERY, accepted in any state: Q <= i_cmd_q (visible in cycle N+1, before the strobe), followed by the new-slot sequence.
- QUERYADJ:
  - Ignored in READY.
  - Otherwise, if updn is 110 then Q=min(Q+1,15); if 011 then Q=max(Q-1,0); if 000 Q is unchanged. Any other code means the whole command is ignored.
  - A valid QUERYADJ is followed by the new-slot sequence.
- QUERYREP:
  - In ARBITRATE: dec-slot sequence.
  - In REPLY: go to ARBITRATE; no strobe.
  - In ACKNOWLEDGED: go to READY.
  - In READY: ignored.
- ACK:
  - In REPLY or ACKNOWLEDGED with i_cmd_rn16==o_rn16: state becomes ACKNOWLEDGED and o_reply_epc pulses in cycle N+1.
  - On mismatch: state becomes ARBITRATE.
  - In READY or ARBITRATE: ignored.
- NAK: any state other than READY goes to ARBITRATE; READY ignores it.
- Type 0, or codes 6/7: ignored, and o_busy is not raised.
- Only one of o_newSlot_cu, o_decSlot_cu, o_reply_rn16, o_reply_epc is ever high in a given cycle.
- Slot wrap: a decrement from 0 is the RNG's responsibility. This block only reacts to slotz.
- Reset asserted mid-sequence: everything returns to reset values immediately, and the pending evaluation is discarded.

Decomposition:
- Shared package (alongside the RNG): state encodings, command-type codes, UPDN codes.
- No sub-module. The Q saturating adjust is a small combinational function kept inside the package.

Test Plan:
- Reset, then QUERY Q=0: o_newSlot_cu pulses at N+1 and o_rn16 captures the RNG value. Slotz=1 at N+3, so state is REPLY at N+4 with a single o_reply_rn16 pulse.
- QUERY Q=4 with RNG low 4 bits=0x3: state ARBITRATE. Three QUERYREPs produce three o_decSlot_cu pulses; after the third, state is REPLY and o_reply_rn16 pulses.
- In REPLY: ACK with matching RN16 gives ACKNOWLEDGED plus an o_reply_epc pulse. ACK with a mismatching value (o_rn16^1) gives ARBITRATE and no pulse.
- Q=15 with QUERYADJ up: Q stays 15. Q=0 with QUERYADJ down: Q stays 0. QUERYADJ updn=3'b101 in ARBITRATE: no strobe and no change.
- QUERY accepted, then a second QUERY at N+1 and N+2 while o_busy=1: both dropped; only one o_newSlot_cu pulse is seen.
- rst_n driven low during WAIT: all outputs return to reset values immediately; no strobe follows after release.
